// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub.
// With PIPE_ADDSUB_OVF_EN defined the bundle also carries the ovf result flag.
interface pipe_addsub_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             c0;
`ifdef PIPE_ADDSUB_OVF_EN
   logic             ovf;

   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, s, c0, ovf);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, s, c0, ovf);
`else
   modport master (output in_valid, a, b, cin, sub, out_ready,
                   input  in_ready, out_valid, s, c0);
   modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                   output in_ready, out_valid, s, c0);
`endif
endinterface

// File: rtl/pipe_addsub.sv
// Elastic pipelined add/sub: the carry chain is cut into STAGES slices, one register per slice.
// Optional macro PIPE_ADDSUB_OVF_EN adds a registered signed-overflow flag (bus.ovf).
module pipe_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic          clk,
   input  logic          rst,
   pipe_addsub_if.slave  bus
);
   localparam int CHUNK = WIDTH / STAGES;

   logic [STAGES:1]             v_q;
   logic [STAGES:1]             c_q;
   logic [STAGES:1][WIDTH-1:0]  res_q;
   logic [WIDTH-1:0]            a_q [1:STAGES];
   logic [WIDTH-1:0]            b_q [1:STAGES];

   logic [STAGES:1]             rdy;
   logic [STAGES:1]             v_in;
   logic [STAGES:1]             c_src;
   logic [STAGES:1]             c_nxt;
   logic [STAGES:1][WIDTH-1:0]  a_src;
   logic [STAGES:1][WIDTH-1:0]  b_src;
   logic [STAGES:1][WIDTH-1:0]  res_src;
   logic [STAGES:1][WIDTH-1:0]  res_nxt;

   always_comb begin : comb_path
      logic           r;
      logic [CHUNK:0] sum;
      // A stage can move if it is empty or everything downstream of it can move.
      r = bus.out_ready;
      for (int k = STAGES; k >= 1; k--) begin
         r      = r | ~v_q[k];
         rdy[k] = r;
      end

      v_in[1]    = bus.in_valid & rdy[1] & ~rst;
      a_src[1]   = bus.a;
      b_src[1]   = bus.sub ? ~bus.b : bus.b;
      c_src[1]   = bus.sub | bus.cin;
      res_src[1] = '0;
      for (int k = 2; k <= STAGES; k++) begin
         v_in[k]    = v_q[k-1];
         a_src[k]   = a_q[k-1];
         b_src[k]   = b_q[k-1];
         c_src[k]   = c_q[k-1];
         res_src[k] = res_q[k-1];
      end

      sum = '0;
      for (int k = 1; k <= STAGES; k++) begin
         sum = {1'b0, a_src[k][(k-1)*CHUNK +: CHUNK]}
             + {1'b0, b_src[k][(k-1)*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_src[k]};
         res_nxt[k]                       = res_src[k];
         res_nxt[k][(k-1)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
         c_nxt[k]                         = sum[CHUNK];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= '0;
         c_q   <= '0;
         res_q <= '0;
         for (int k = 1; k <= STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
         end
      end else begin
         for (int k = 1; k <= STAGES; k++) begin
            if (rdy[k]) begin
               v_q[k] <= v_in[k];
               // Data only captured with a valid op so a bubble never disturbs s.
               if (v_in[k]) begin
                  res_q[k] <= res_nxt[k];
                  c_q[k]   <= c_nxt[k];
                  a_q[k]   <= a_src[k];
                  b_q[k]   <= b_src[k];
               end
            end
         end
      end
   end

   assign bus.in_ready  = rdy[1] & ~rst;
   assign bus.out_valid = v_q[STAGES];
   assign bus.s         = res_q[STAGES];
   assign bus.c0        = c_q[STAGES];

`ifdef PIPE_ADDSUB_OVF_EN
   logic ovf_q;
   logic ovf_nxt;

   // Carry into the MSB is recovered from the MSB sum bit and its operands.
   assign ovf_nxt = a_src[STAGES][WIDTH-1] ^ b_src[STAGES][WIDTH-1]
                  ^ res_nxt[STAGES][WIDTH-1] ^ c_nxt[STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (rdy[STAGES] && v_in[STAGES]) begin
         ovf_q <= ovf_nxt;
      end
   end

   assign bus.ovf = ovf_q;
`endif
endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined successor to the team's ripple-carry adder family.
- Adds or subtracts two WIDTH-bit operands. The carry chain is split into STAGES equal slices, with one register stage per slice.
- Valid/ready handshakes on input and output. Full throughput of 1 op/cycle; backpressure is honoured without losing data.
- Used wherever a wide add/sub must meet timing inside a streaming datapath.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages (1..WIDTH). Slice width CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands/mode valid
- in_ready  output  1  block can accept; transfer when in_valid & in_ready at rising edge
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add mode only)
- sub  input  1  1: s = a - b; 0: s = a + b + cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready at rising edge
- s  output  WIDTH  sum/difference
- c0  output  1  carry-out of MSB; in sub mode 1 = no borrow (a >= b unsigned)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset state, applied at the first rising edge with rst=1:
  - all stage valids = 0; all stage data registers = 0.
  - out_valid = 0, s = 0, c0 = 0.
  - in_ready = 0 while rst=1.
  - in_valid is ignored while rst=1.
- Reset mid-operation discards all in-flight operations; no result for them is ever presented.
- Operand conditioning at input:
  - sub=0: b_eff = b, carry seed = cin.
  - sub=1: b_eff = ~b, carry seed = 1; cin is ignored.
- Stage k (1..STAGES) adds slice [k*CHUNK-1 : (k-1)*CHUNK] of a and b_eff plus the carry registered by stage k-1 (stage 1 uses the carry seed). It registers:
  - the completed lower result slices,
  - the slice carry,
  - the still-unprocessed upper a/b_eff slices.
- Stage STAGES registers drive s and c0 directly; no combinational path from a/b to s.
- Latency: an op accepted at edge n is presented (out_valid=1) starting right after edge n+STAGES-1, if never stalled. STAGES=1 gives a single registered adder.
- Elastic flow control, per stage k with valid v_k:
  - rdy_STAGES = !v_STAGES | out_ready
  - rdy_k = !v_k | rdy_{k+1}
  - in_ready = rdy_1 (and !rst).
  - Stage k loads from stage k-1 when rdy_k. v_k takes v_{k-1} (stage 1 takes in_valid & in_ready).
  - When !rdy_k, stage k holds its data and valid unchanged.
- Full pipeline with out_ready=1: accepts and retires one op per cycle, with no bubbles.
- out_ready=0 with out_valid=1: s and c0 stay stable until accepted.
- Bubbles in the pipeline are compressed while the output is stalled.
- Simultaneous input accept and output retire in the same cycle is legal, including when the pipeline is full.
- Ops retire strictly in acceptance order; sub/cin travel with their own op.
- Arithmetic is modulo 2^WIDTH. c0 is bit WIDTH of the full add of a + b_eff + seed.

Optional Feature:
- Macro: PIPE_ADDSUB_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), registered alongside s.
  - ovf = signed two's-complement overflow of the op: carry into MSB XOR carry out of MSB.
  - ovf is reset to 0 and held with s during stalls.
- Not defined: no ovf port and no related logic.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, s=0, c0=0. No output appears after rst drops.
- Latency (WIDTH=32, STAGES=4), out_ready=1: add a=0xFFFFFFFF, b=0x00000001, cin=0, accepted at edge n -> out_valid after edge n+3 with s=0x00000000, c0=1. The carry ripples across all four slices.
- Subtract: a=5, b=7, sub=1, cin=1 -> s=0xFFFFFFFE, c0=0, showing cin is ignored. Then a=7, b=5 -> s=2, c0=1.
- Backpressure: stream 8 back-to-back adds (a=i, b=0x10*i) with out_ready low on cycles 3-6:
  - in_ready drops once the pipeline fills;
  - all 8 results emerge in order, s = 0x11*i, with none lost or duplicated;
  - s is stable while stalled.
- Throughput: continuous in_valid and out_ready=1 for 100 random ops -> one result per cycle after the initial latency. Results match a reference model including c0.
- Reset mid-stream with 3 ops in flight -> out_valid=0 after the reset edge. None of the 3 flushed ops appear. The next op accepted after reset returns correctly after 4 cycles.
- With PIPE_ADDSUB_OVF_EN: a=0x7FFFFFFF, b=1, add -> ovf=1. a=0x80000000, b=1, sub -> ovf=1. a=1, b=1 -> ovf=0.
